// File: rtl/uart_tx_path.sv
// UART transmit path: byte FIFO feeding an 8N1 serialiser (LSB first) with its own baud-tick divider.
// Build option UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_path #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 4,
    parameter int DVSR_W  = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   d_in,
    output logic              tx,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              tx_busy
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam int S_W   = $clog2(SB_TICK);
    localparam int N_W   = $clog2(DBIT);

    localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
    localparam logic [DVSR_W-1:0]  CNT_ONE = DVSR_W'(1);
    localparam logic [S_W-1:0]     S_ONE   = S_W'(1);
    localparam logic [S_W-1:0]     S_LAST  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0]     N_ONE   = N_W'(1);
    localparam logic [N_W-1:0]     N_LAST  = N_W'(DBIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [DBIT-1:0]    mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic               full_q, empty_q;
    logic               push, pop;
    logic [DBIT-1:0]    head;

    logic [DVSR_W-1:0]  tick_cnt;
    logic               tick;

    logic [2:0]         state, state_n;
    logic [S_W-1:0]     s_q, s_n;
    logic [N_W-1:0]     n_q, n_n;
    logic [DBIT-1:0]    b_q, b_n;
    logic               tx_q, tx_n;
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_n;
`endif

    // A full FIFO still accepts a write in the cycle the serialiser pops a byte.
    assign push       = wr_en && (!full_q || pop);
    assign wr_ptr_nxt = wr_ptr + PTR_ONE;
    assign rd_ptr_nxt = rd_ptr + PTR_ONE;
    assign head       = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and flags alone define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= d_in;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            case ({push, pop})
                2'b10: begin
                    wr_ptr  <= wr_ptr_nxt;
                    empty_q <= 1'b0;
                    full_q  <= (wr_ptr_nxt == rd_ptr);
                end
                2'b01: begin
                    rd_ptr  <= rd_ptr_nxt;
                    full_q  <= 1'b0;
                    empty_q <= (rd_ptr_nxt == wr_ptr);
                end
                2'b11: begin
                    wr_ptr <= wr_ptr_nxt;
                    rd_ptr <= rd_ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    // Restarting the divider when a frame begins makes the start bit exactly one bit period long.
    assign tick = (tick_cnt == dvsr);

    always_ff @(posedge clk) begin
        if (reset || (state == IDLE && !empty_q))
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_ONE;
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        state_n = state;
        s_n     = s_q;
        n_n     = n_q;
        b_n     = b_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: pop = !empty_q;
            START: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_n     = '0;
                        n_n     = '0;
                        state_n = DATA;
                    end else begin
                        s_n = s_q + S_ONE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_n = '0;
                        b_n = b_q >> 1;
                        if (n_q == N_LAST)
`ifdef UART_TX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        else
                            n_n = n_q + N_ONE;
                    end else begin
                        s_n = s_q + S_ONE;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_n     = '0;
                        state_n = STOP;
                    end else begin
                        s_n = s_q + S_ONE;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_q == S_LAST) begin
                        s_n = '0;
                        if (!empty_q)
                            pop = 1'b1;
                        else
                            state_n = IDLE;
                    end else begin
                        s_n = s_q + S_ONE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Loading a new byte is shared by IDLE and the gapless STOP -> START path.
        if (pop) begin
            b_n     = head;
            s_n     = '0;
            n_n     = '0;
            state_n = START;
`ifdef UART_TX_PARITY_EN
            par_n   = ^head;
`endif
        end

        // tx is registered from the next state so the line changes on the same edge as the FSM.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = b_n[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_n = par_n;
`endif
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_q   <= '0;
            n_q   <= '0;
            b_q   <= '0;
            tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s_q   <= s_n;
            n_q   <= n_n;
            b_q   <= b_n;
            tx_q  <= tx_n;
`ifdef UART_TX_PARITY_EN
            par_q <= par_n;
`endif
        end
    end

    assign tx       = tx_q;
    assign tx_full  = full_q;
    assign tx_empty = empty_q;
    assign tx_busy  = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: checks timing and frames against a line-level model (mid-bit sampling receiver).
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_path;
    localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] dvsr;
    logic        wr_en;
    logic [7:0]  d_in;
    logic        tx, tx_full, tx_empty, tx_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_tx_path dut (
        .clk      (clk),
        .reset    (reset),
        .dvsr     (dvsr),
        .wr_en    (wr_en),
        .d_in     (d_in),
        .tx       (tx),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_busy  (tx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Line receiver: find a start bit, then sample each bit in the middle of its period.
    task automatic recv(input int p, input int limit, output logic [7:0] data,
                        output logic par, output int t_start, output logic ok);
        int w = 0;
        ok = 1'b1;
        data = '0;
        par = 1'b0;
        t_start = cyc;
        while (tx !== 1'b0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        t_start = cyc;
        repeat (p / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < DBIT; i++) begin
            repeat (p) @(negedge clk);
            data[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (p) @(negedge clk);
        par = tx;
`endif
        repeat (p) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic expect_frame(input string tag, input int p, input logic [7:0] exp, input int limit);
        logic [7:0] data;
        logic       par, ok;
        int         t;
        recv(p, limit, data, par, t, ok);
        check({tag, "_framing"}, ok, 1'b1);
        check(tag, data, exp);
`ifdef UART_TX_PARITY_EN
        check({tag, "_parity"}, par, ^exp);
`endif
    endtask

    logic [7:0] bt;
    logic       etx, ebusy;
    int         k, w;
    int         t0, t1, t2;
    logic [7:0] r0, r1, r2;
    logic       p0, p1, p2, ok0, ok1, ok2;
    logic [7:0] b4 [18];
    logic [7:0] xb;
    logic [FRAME_BITS-2:0] fb;
    logic [7:0] q [$];

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        d_in  = '0;
        dvsr  = 11'd7;

        // Reset and idle: line high, FIFO empty, FSM idle.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            check("t1_idle", {tx, tx_empty, tx_busy, tx_full}, 4'b1100);
        end

        // Single 0xA5 frame compared cycle by cycle against the ideal waveform.
        do_reset();
        bt = 8'hA5;
        wr_en = 1'b1;
        d_in  = bt;
        for (int c = 1; c <= FRAME_BITS * 128 + 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                wr_en = 1'b0;
                check("t2_not_empty", tx_empty, 1'b0);
            end
            if (c == 2) check("t2_popped", tx_empty, 1'b1);
            etx = 1'b1;
            if (c >= 2 && c < 130) etx = 1'b0;
            else if (c >= 130) begin
                k = (c - 130) / 128;
                if (k < 8) etx = bt[k];
`ifdef UART_TX_PARITY_EN
                else if (k == 8) etx = ^bt;
`endif
            end
            ebusy = (c >= 2 && c < 2 + FRAME_BITS * 128);
            check("t2_wave", {tx, tx_busy}, {etx, ebusy});
        end

        // Three back-to-back bytes: contiguous frames, FIFO drained by the third pop.
        do_reset();
        fork
            begin
                wr_en = 1'b1; d_in = 8'h01; @(negedge clk);
                d_in = 8'h80; @(negedge clk);
                d_in = 8'hFF; @(negedge clk);
                wr_en = 1'b0;
                check("t3_queued", tx_empty, 1'b0);
            end
            begin
                recv(128, 400, r0, p0, t0, ok0);
                recv(128, 400, r1, p1, t1, ok1);
                recv(128, 400, r2, p2, t2, ok2);
            end
        join
        check("t3_ok", {ok0, ok1, ok2}, 3'b111);
        check("t3_b0", r0, 8'h01);
        check("t3_b1", r1, 8'h80);
        check("t3_b2", r2, 8'hFF);
        check("t3_gap01", t1 - t0, FRAME_BITS * 128);
        check("t3_gap12", t2 - t1, FRAME_BITS * 128);
        check("t3_empty", tx_empty, 1'b1);
        repeat (70) @(negedge clk);
        check("t3_done", tx_busy, 1'b0);

        // Random bytes, random divisor, bursty writes; receiver compares against a queue.
        for (int round = 0; round < 2; round++) begin
            do_reset();
            dvsr = 11'($urandom_range(0, 2));
            q.delete();
            fork
                begin
                    for (int i = 0; i < 10; i++) begin
                        if ($urandom_range(0, 3) == 0)
                            repeat ($urandom_range(1, 2 * FRAME_BITS * 16 * (dvsr + 1))) @(negedge clk);
                        w = 0;
                        while (tx_full && w < 10000) begin
                            @(negedge clk);
                            w++;
                        end
                        wr_en = 1'b1;
                        d_in  = 8'($urandom);
                        q.push_back(d_in);
                        @(negedge clk);
                        wr_en = 1'b0;
                    end
                end
                begin
                    for (int i = 0; i < 10; i++) begin
                        recv(16 * (dvsr + 1), 4 * FRAME_BITS * 16 * (dvsr + 1) + 50, r0, p0, t0, ok0);
                        check("rnd_framing", ok0, 1'b1);
                        check("rnd_have_exp", q.size() > 0, 1'b1);
                        if (q.size() > 0) begin
                            bt = q.pop_front();
                            check("rnd_byte", r0, bt);
`ifdef UART_TX_PARITY_EN
                            check("rnd_parity", p0, ^bt);
`endif
                        end
                    end
                end
            join
        end

        // FIFO overflow: serialiser stalled by a huge divisor, 18 writes -> 16 queued + 1 on the line.
        do_reset();
        dvsr = 11'h7FF;
        for (int i = 0; i < 18; i++) begin
            b4[i] = 8'($urandom);
            if (i == 0) b4[i][0] = 1'b1;
            wr_en = 1'b1;
            d_in  = b4[i];
            if (i == 16) check("t4_not_full", tx_full, 1'b0);
            @(negedge clk);
        end
        check("t4_full", tx_full, 1'b1);
        // Hold a write while full; only the one coinciding with the next pop may be accepted.
        xb   = 8'($urandom);
        d_in = xb;
        dvsr = 11'd0;
        w = 0;
        while (tx !== 1'b1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("t4_start_end", tx, 1'b1);
        for (int off = 0; off < (FRAME_BITS - 1) * 16; off++) begin
            if (off % 16 == 8) fb[off / 16] = tx;
            @(negedge clk);
        end
        check("t4_next_start", tx, 1'b0);
        wr_en = 1'b0;
        check("t4_frame0", fb[7:0], b4[0]);
        check("t4_frame0_stop", fb[FRAME_BITS-2], 1'b1);
`ifdef UART_TX_PARITY_EN
        check("t4_frame0_parity", fb[8], ^b4[0]);
`endif
        for (int i = 1; i <= 16; i++) expect_frame("t4_frame", 16, b4[i], 400);
        expect_frame("t4_pop_write", 16, xb, 400);
        repeat (20) @(negedge clk);
        check("t4_drained", {tx_empty, tx_busy}, 2'b10);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            check("t4_no_extra", tx, 1'b1);
        end

        // Reset in the middle of a 0x3C data bit (bit1 = 0) aborts the frame and flushes the FIFO.
        do_reset();
        dvsr = 11'd7;
        wr_en = 1'b1;
        d_in = 8'h3C;          @(negedge clk);
        d_in = 8'($urandom);   @(negedge clk);
        d_in = 8'($urandom);   @(negedge clk);
        wr_en = 1'b0;
        repeat (297) @(negedge clk);
        check("t5_mid_data", {tx, tx_busy}, 2'b01);
        reset = 1'b1;
        @(negedge clk);
        check("t5_after_reset", {tx, tx_empty, tx_busy, tx_full}, 4'b1100);
        reset = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            check("t5_quiet", {tx, tx_busy}, 2'b10);
        end

`ifdef UART_TX_PARITY_EN
        // Parity values for 0x07 (odd weight) and 0x03 (even weight).
        do_reset();
        dvsr = 11'd7;
        fork
            begin
                wr_en = 1'b1; d_in = 8'h07; @(negedge clk);
                wr_en = 1'b0;
            end
            recv(128, 400, r0, p0, t0, ok0);
        join
        check("t6_07_ok", ok0, 1'b1);
        check("t6_07_data", r0, 8'h07);
        check("t6_07_parity", p0, 1'b1);
        repeat (70) @(negedge clk);
        fork
            begin
                wr_en = 1'b1; d_in = 8'h03; @(negedge clk);
                wr_en = 1'b0;
            end
            recv(128, 400, r1, p1, t1, ok1);
        join
        check("t6_03_ok", ok1, 1'b1);
        check("t6_03_data", r1, 8'h03);
        check("t6_03_parity", p1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
